// File: rtl/serial_add_sub_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives the request side; the slave (the datapath) returns status and results.
interface serial_add_sub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flop, LSB first, one bit per clock.
// Subtraction is a + ~b + ~borrow_in; the final carry is inverted to report a borrow.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    serial_add_sub_if.slave  bus_io
);
    localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_c;

    assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
    assign fa_c = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    state_d = StRun;
                    a_d     = bus_io.a;
                    b_d     = bus_io.sub ? ~bus_io.b : bus_io.b;
                    c_d     = bus_io.cin ^ bus_io.sub;
                    sub_d   = bus_io.sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            StRun: begin
                sum_d = {fa_s, sum_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = fa_c;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    cout_d  = fa_c ^ sub_q;
                    // Signed overflow: carry into the MSB differs from carry out of it.
                    ovf_d   = c_q ^ fa_c;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus_io.busy     = (state_q != StIdle);
    assign bus_io.done     = (state_q == StDone);
    assign bus_io.sum      = sum_q;
    assign bus_io.cout     = cout_q;
    assign bus_io.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: directed and random operations on 8- and 16-bit instances,
// checked against an arithmetic reference model.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8))  bus8 ();
    serial_add_sub_if #(.WIDTH(16)) bus16 ();

    serial_add_sub #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus8)
    );

    serial_add_sub #(.WIDTH(16)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus16)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint unsigned v, input int w);
        if (((v >> (w - 1)) & 64'd1) != 64'd0) return longint'(v) - (longint'(1) <<< w);
        return longint'(v);
    endfunction

    // Reference: plain unsigned arithmetic for sum/carry, signed range check for overflow.
    task automatic model(input int w, input longint unsigned a, input longint unsigned b,
                         input logic sub, input logic cin,
                         output longint unsigned s, output logic co, output logic ov);
        longint unsigned mask;
        longint unsigned ur;
        longint          r;
        longint          ci;
        ci   = longint'({63'd0, cin});
        mask = (64'd1 << w) - 64'd1;
        if (!sub) begin
            ur = a + b + longint'(ci);
            co = ((ur >> w) & 64'd1) != 64'd0;
            r  = sx(a, w) + sx(b, w) + ci;
        end else begin
            ur = a - b - longint'(ci);
            co = (a < b + longint'(ci));
            r  = sx(a, w) - sx(b, w) - ci;
        end
        s  = ur & mask;
        ov = (r > ((longint'(1) <<< (w - 1)) - 1)) || (r < -(longint'(1) <<< (w - 1)));
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                        input logic cin, input int pulse_at, input string tag);
        longint unsigned es;
        logic            ec, eo;
        model(8, 64'(a), 64'(b), sub, cin, es, ec, eo);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.sub = sub; bus8.cin = cin; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            if (n == 2) begin
                bus8.a   = 8'($urandom);
                bus8.b   = 8'($urandom);
                bus8.sub = 1'($urandom);
                bus8.cin = 1'($urandom);
            end
            if (n == pulse_at)     bus8.start = 1'b1;
            if (n == pulse_at + 1) bus8.start = 1'b0;
            check({tag, "/busy"}, 64'(bus8.busy), 64'(n <= 9));
            check({tag, "/done"}, 64'(bus8.done), 64'(n == 9));
            if (n >= 9) begin
                check({tag, "/sum"},  64'(bus8.sum), es);
                check({tag, "/cout"}, 64'(bus8.cout), 64'(ec));
                check({tag, "/ovf"},  64'(bus8.overflow), 64'(eo));
            end
            @(negedge clk);
        end
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         input logic cin, input string tag);
        longint unsigned es;
        logic            ec, eo;
        model(16, 64'(a), 64'(b), sub, cin, es, ec, eo);
        @(negedge clk);
        bus16.a = a; bus16.b = b; bus16.sub = sub; bus16.cin = cin; bus16.start = 1'b1;
        @(negedge clk);
        bus16.start = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            check({tag, "/busy"}, 64'(bus16.busy), 64'(n <= 17));
            check({tag, "/done"}, 64'(bus16.done), 64'(n == 17));
            if (n >= 17) begin
                check({tag, "/sum"},  64'(bus16.sum), es);
                check({tag, "/cout"}, 64'(bus16.cout), 64'(ec));
                check({tag, "/ovf"},  64'(bus16.overflow), 64'(eo));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        longint unsigned es;
        logic            ec, eo;
        int              k;

        bus8.start = 1'b0; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.a = '0; bus8.b = '0;
        bus16.start = 1'b0; bus16.sub = 1'b0; bus16.cin = 1'b0; bus16.a = '0; bus16.b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst/busy", 64'(bus8.busy), 64'd0);
        check("rst/done", 64'(bus8.done), 64'd0);
        check("rst/sum",  64'(bus8.sum), 64'd0);
        check("rst/cout", 64'(bus8.cout), 64'd0);
        check("rst/ovf",  64'(bus8.overflow), 64'd0);
        check("rst/busy16", 64'(bus16.busy), 64'd0);
        rst_n = 1'b1;

        // Directed cases
        run8(8'h35, 8'h4A, 1'b0, 1'b0, 0, "add_35_4a");
        run8(8'hFF, 8'h01, 1'b0, 1'b1, 0, "add_ff_01_c");
        run8(8'h7F, 8'h01, 1'b0, 1'b0, 0, "add_ovf");
        run8(8'h80, 8'h01, 1'b1, 1'b0, 0, "sub_ovf");
        run8(8'h10, 8'h20, 1'b1, 1'b0, 0, "sub_borrow");
        run8(8'h20, 8'h10, 1'b1, 1'b1, 0, "sub_bin");

        // start pulsed during RUN cycle 3 must be ignored
        run8(8'h5C, 8'h21, 1'b0, 1'b1, 3, "ignore_start");

        // start held high: re-accepted at the first IDLE edge after DONE
        model(8, 64'h3C, 64'h0F, 1'b1, 1'b0, es, ec, eo);
        @(negedge clk);
        bus8.a = 8'h3C; bus8.b = 8'h0F; bus8.sub = 1'b1; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        k = 0;
        while (!bus8.done && k < 20) begin @(negedge clk); k++; end
        check("hold/first_done_lat", 64'(k), 64'd8);
        @(negedge clk);
        check("hold/idle_gap", 64'(bus8.busy), 64'd0);
        @(negedge clk);
        check("hold/reaccept", 64'(bus8.busy), 64'd1);
        bus8.start = 1'b0;
        k = 0;
        while (!bus8.done && k < 20) begin @(negedge clk); k++; end
        check("hold/second_done_lat", 64'(k), 64'd8);
        check("hold/sum",  64'(bus8.sum), es);
        check("hold/cout", 64'(bus8.cout), 64'(ec));
        check("hold/ovf",  64'(bus8.overflow), 64'(eo));
        @(negedge clk);

        // Reset asserted in RUN cycle 5 abandons the operation
        @(negedge clk);
        bus8.a = 8'hA5; bus8.b = 8'h5A; bus8.sub = 1'b0; bus8.cin = 1'b0; bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst/busy", 64'(bus8.busy), 64'd0);
        check("midrst/sum",  64'(bus8.sum), 64'd0);
        check("midrst/cout", 64'(bus8.cout), 64'd0);
        check("midrst/ovf",  64'(bus8.overflow), 64'd0);
        check("midrst/done", 64'(bus8.done), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            check("midrst/no_done", 64'(bus8.done), 64'd0);
            @(negedge clk);
        end

        run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "w16_ffff_1");

        // Random operations
        for (int i = 0; i < 12; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 0, "rand8");
        for (int i = 0; i < 4; i++)
            run16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "rand16");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
